// File: rtl/mem_lane_align_pkg.sv
// Shared types and funct3 encodings for the MEM-stage byte-lane alignment unit.
package mem_lane_align_pkg;

  typedef logic [63:0] u64;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_D  = 3'b011;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;
  localparam logic [2:0] MODE_WU = 3'b110;

endpackage

// File: rtl/mem_lane_align_load_extract.sv
// Load-side extraction: shift the raw bus word down to the access offset, then
// sign- or zero-extend the selected bytes according to funct3.
module mem_load_extract
  import mem_lane_align_pkg::*;
(
  input  u64         raw,
  input  logic [2:0] off,
  input  logic [2:0] mem_mode,
  output u64         load_data
);

  u64 sh;

  always_comb begin
    sh = raw >> {off, 3'b000};
    load_data = sh;
    case (mem_mode)
      MODE_B:  load_data = {{56{sh[7]}}, sh[7:0]};
      MODE_BU: load_data = {56'd0, sh[7:0]};
      MODE_H:  load_data = {{48{sh[15]}}, sh[15:0]};
      MODE_HU: load_data = {48'd0, sh[15:0]};
      MODE_W:  load_data = {{32{sh[31]}}, sh[31:0]};
      MODE_WU: load_data = {32'd0, sh[31:0]};
      default: load_data = sh;
    endcase
  end

endmodule

// File: rtl/mem_lane_align.sv
// Byte-lane alignment between the MEM stage and the 64-bit data bus: combinational
// request shaping plus a captured read word that is extracted into a load result.
module mem_lane_align
  import mem_lane_align_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  u64         address_req,
  input  u64         data_in,
  input  logic [2:0] mem_mode,
  output u64         addr,
  output msize_t     msize,
  output strobe_t    strobe,
  output u64         data,
  output logic       misaligned,
  input  logic       resp_valid,
  input  u64         resp_data,
  output u64         load_data
);

  logic [2:0] off;
  strobe_t    mask;
  u64         raw;

  assign off  = address_req[2:0];
  assign addr = address_req;

  // Size comes only from funct3[1:0], so unsigned variants and 111 share the signed decode.
  always_comb begin
    mask       = 8'h01;
    msize      = MSIZE1;
    misaligned = 1'b0;
    case (mem_mode[1:0])
      2'b00: begin
        mask  = 8'h01;
        msize = MSIZE1;
      end
      2'b01: begin
        mask       = 8'h03;
        msize      = MSIZE2;
        misaligned = off[0];
      end
      2'b10: begin
        mask       = 8'h0F;
        msize      = MSIZE4;
        misaligned = |off[1:0];
      end
      default: begin
        mask       = 8'hFF;
        msize      = MSIZE8;
        misaligned = |off;
      end
    endcase
  end

  assign strobe = mask << off;
  assign data   = data_in << {off, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      raw <= '0;
    else if (resp_valid)
      raw <= resp_data;
  end

  mem_load_extract u_extract (
    .raw       (raw),
    .off       (off),
    .mem_mode  (mem_mode),
    .load_data (load_data)
  );

endmodule

// File: tb/tb_mem_lane_align.sv
// Directed self-checking bench for mem_lane_align using immediate assertions.
module tb_mem_lane_align;
  import mem_lane_align_pkg::*;

  logic       clk;
  logic       rst;
  u64         address_req;
  u64         data_in;
  logic [2:0] mem_mode;
  u64         addr;
  msize_t     msize;
  strobe_t    strobe;
  u64         data;
  logic       misaligned;
  logic       resp_valid;
  u64         resp_data;
  u64         load_data;

  int compared;
  int mismatched;

  mem_lane_align dut (
    .clk         (clk),
    .rst         (rst),
    .address_req (address_req),
    .data_in     (data_in),
    .mem_mode    (mem_mode),
    .addr        (addr),
    .msize       (msize),
    .strobe      (strobe),
    .data        (data),
    .misaligned  (misaligned),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .load_data   (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input u64 observed, input u64 expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input u64 a, input u64 d, input logic [2:0] m);
    address_req = a;
    data_in     = d;
    mem_mode    = m;
    #1;
  endtask

  task automatic capture(input u64 d);
    @(negedge clk);
    resp_data  = d;
    resp_valid = 1'b1;
    @(posedge clk);
    #1;
    resp_valid = 1'b0;
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b1;
    resp_valid  = 1'b0;
    resp_data   = '0;
    address_req = '0;
    data_in     = '0;
    mem_mode    = MODE_D;
    repeat (2) @(negedge clk);
    check_output("reset_load", load_data, 64'h0);
    rst = 1'b0;

    // Store-side request shaping.
    @(negedge clk);
    apply_stimulus(64'h1003, 64'hAB, MODE_B);
    check_output("sb_addr", addr, 64'h1003);
    check_output("sb_msize", 64'(msize), 64'd0);
    check_output("sb_strobe", 64'(strobe), 64'h08);
    check_output("sb_data", data, 64'h0000_0000_AB00_0000);
    check_output("sb_mis", 64'(misaligned), 64'd0);

    apply_stimulus(64'h2004, 64'h1122_3344, MODE_W);
    check_output("sw_msize", 64'(msize), 64'd2);
    check_output("sw_strobe", 64'(strobe), 64'hF0);
    check_output("sw_data", data, 64'h1122_3344_0000_0000);
    check_output("sw_mis", 64'(misaligned), 64'd0);

    apply_stimulus(64'h2000, 64'h0102_0304_0506_0708, MODE_D);
    check_output("sd_msize", 64'(msize), 64'd3);
    check_output("sd_strobe", 64'(strobe), 64'hFF);
    check_output("sd_data", data, 64'h0102_0304_0506_0708);

    apply_stimulus(64'h3006, 64'hBEEF, MODE_H);
    check_output("sh6_strobe", 64'(strobe), 64'hC0);
    check_output("sh6_mis", 64'(misaligned), 64'd0);

    // Byte loads, signed and unsigned.
    apply_stimulus(64'h4002, 64'h0, MODE_B);
    capture(64'h0000_0000_0080_0000);
    check_output("lb", load_data, 64'hFFFF_FFFF_FFFF_FF80);
    apply_stimulus(64'h4002, 64'h0, MODE_BU);
    check_output("lbu", load_data, 64'h80);

    // Word and doubleword loads.
    capture(64'h8000_0001_0000_0000);
    apply_stimulus(64'h5004, 64'h0, MODE_W);
    check_output("lw", load_data, 64'hFFFF_FFFF_8000_0001);
    apply_stimulus(64'h5004, 64'h0, MODE_WU);
    check_output("lwu", load_data, 64'h0000_0000_8000_0001);
    apply_stimulus(64'h5000, 64'h0, MODE_D);
    check_output("ld", load_data, 64'h8000_0001_0000_0000);
    apply_stimulus(64'h5000, 64'h0, 3'b111);
    check_output("mode111", load_data, 64'h8000_0001_0000_0000);

    // Misaligned accesses are truncated, not merged.
    apply_stimulus(64'h5007, 64'h0, MODE_H);
    check_output("lh7_mis", 64'(misaligned), 64'd1);
    check_output("lh7_strobe", 64'(strobe), 64'h80);
    check_output("lh7_load", load_data, 64'h80);
    apply_stimulus(64'h6002, 64'hCAFE_F00D, MODE_W);
    check_output("sw2_mis", 64'(misaligned), 64'd1);
    check_output("sw2_strobe", 64'(strobe), 64'h3C);
    check_output("sw2_data", data, 64'h0000_CAFE_F00D_0000);
    apply_stimulus(64'h6001, 64'h0, MODE_D);
    check_output("sd1_mis", 64'(misaligned), 64'd1);

    // Register holds when resp_valid is low.
    apply_stimulus(64'h7000, 64'h0, MODE_D);
    capture(64'hDEAD);
    check_output("cap_dead", load_data, 64'hDEAD);
    @(negedge clk);
    resp_data = 64'h1234;
    @(posedge clk);
    #1;
    check_output("hold", load_data, 64'hDEAD);

    // Asynchronous reset mid-cycle, then reset dominates a capture.
    #2;
    rst = 1'b1;
    #1;
    check_output("async_rst", load_data, 64'h0);
    @(negedge clk);
    resp_data  = 64'h5555;
    resp_valid = 1'b1;
    @(posedge clk);
    #1;
    resp_valid = 1'b0;
    check_output("rst_dominates", load_data, 64'h0);
    check_output("rst_req_follows", 64'(strobe), 64'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
